// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instruction_loader_pkg;

   localparam int BYTE_SIZE = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECEIVE = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OVERFLOW = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into words; first byte lands in the MSBs.
// Latency: word and complete are combinational on the byte that finishes a word.
// Backpressure: none; every valid byte is taken (WORD_SIZE_IN_BYTES must be >= 2).
module word_assembler #(
   parameter int WORD_SIZE_IN_BYTES = 4,
   parameter int BYTE_SIZE          = 8
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   clear,
   input  logic [BYTE_SIZE-1:0]                   data,
   input  logic                                   valid,
   output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] word,
   output logic                                   complete,
   output logic                                   partial
);

   localparam int SHIFT_W = (WORD_SIZE_IN_BYTES - 1) * BYTE_SIZE;
   localparam int IDX_W   = $clog2(WORD_SIZE_IN_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE_IN_BYTES - 1);

   // Only the bytes already received are stored; the final byte is
   // spliced in combinationally so the word is ready on its own edge.
   logic [SHIFT_W-1:0] shift;
   logic [IDX_W-1:0]   idx;

   assign word     = {shift, data};
   assign complete = valid && (idx == LAST_IDX);
   assign partial  = (idx != '0);

   // Shift in each accepted byte and advance the index, wrapping on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift <= '0;
         idx   <= '0;
      end else if (clear) begin
         shift <= '0;
         idx   <= '0;
      end else if (valid) begin
         shift <= word[SHIFT_W-1:0];
         idx   <= complete ? '0 : idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Turns a byte stream into instruction words and strobes them into instruction memory.
// Latency: write strobe one cycle after the last byte of a word is accepted.
// Backpressure: none; bytes are ignored outside RECEIVE, never dropped inside it.
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int WORD_SIZE_IN_BYTES = 4,
   parameter int MEM_SIZE_IN_WORDS  = 10,
   parameter int TIMEOUT_CYCLES     = 100000,
   parameter logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] HALT_WORD = '0
) (
   input  logic                                     i_clk,
   input  logic                                     i_reset,
   input  logic                                     i_start,
   input  logic [BYTE_SIZE-1:0]                     i_byte,
   input  logic                                     i_byte_valid,
   output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0]  o_instruction,
   output logic                                     o_instruction_write,
   output logic [$clog2(MEM_SIZE_IN_WORDS+1)-1:0]   o_word_count,
   output logic                                     o_busy,
   output logic                                     o_done,
   output logic [1:0]                               o_error
);

   localparam int WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
   localparam int CNT_W  = $clog2(MEM_SIZE_IN_WORDS + 1);
   localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(MEM_SIZE_IN_WORDS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t              state;
   state_t              state_next;
   logic                accept;
   logic                start_ok;
   logic                asm_clear;
   logic [WORD_W-1:0]   asm_word;
   logic                word_complete;
   logic                asm_partial;
   logic                is_halt;
   logic                at_limit;
   logic                timer_expired;
   logic [TMR_W-1:0]    timer;

   assign accept        = i_byte_valid && (state == ST_RECEIVE);
   assign start_ok      = i_start && (state != ST_RECEIVE);
   assign is_halt       = (asm_word == HALT_WORD);
   assign at_limit      = (o_word_count == LAST_SLOT);
   // Only a partially received word can time out; an empty assembler waits forever.
   assign timer_expired = (state == ST_RECEIVE) && asm_partial && !i_byte_valid
                          && (timer == TMR_LAST);
   assign asm_clear     = start_ok || timer_expired;
   assign o_busy        = (state == ST_RECEIVE);

   word_assembler #(
      .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES),
      .BYTE_SIZE          (BYTE_SIZE)
   ) u_word_assembler (
      .clk      (i_clk),
      .rst_n    (i_reset),
      .clear    (asm_clear),
      .data     (i_byte),
      .valid    (accept),
      .word     (asm_word),
      .complete (word_complete),
      .partial  (asm_partial)
   );

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: halt, overflow and timeout all end the load in DONE.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (i_start) state_next = ST_RECEIVE;
         end
         ST_RECEIVE: begin
            if (word_complete && (is_halt || at_limit)) begin
               state_next = ST_DONE;
            end else if (timer_expired) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_start) state_next = ST_RECEIVE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Word output, write strobe, word counter, status flags and idle timer.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_instruction       <= '0;
         o_instruction_write <= 1'b0;
         o_word_count        <= '0;
         o_done              <= 1'b0;
         o_error             <= ERR_NONE;
         timer               <= '0;
      end else begin
         o_instruction_write <= 1'b0;
         if (start_ok) begin
            o_word_count <= '0;
            o_done       <= 1'b0;
            o_error      <= ERR_NONE;
            timer        <= '0;
         end else if (state == ST_RECEIVE) begin
            if (word_complete) begin
               o_instruction       <= asm_word;
               o_instruction_write <= 1'b1;
               o_word_count        <= o_word_count + CNT_W'(1);
               // A halt in the last slot is a clean finish, so it wins over overflow.
               if (is_halt) begin
                  o_done <= 1'b1;
               end else if (at_limit) begin
                  o_error <= ERR_OVERFLOW;
               end
            end
            if (accept) begin
               timer <= '0;
            end else if (timer_expired) begin
               o_error <= ERR_TIMEOUT;
               timer   <= '0;
            end else if (asm_partial) begin
               timer <= timer + TMR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a behavioural instruction memory.
// Latency: checks the strobe one cycle after each final byte.
// Backpressure: n/a.
module tb_instruction_loader;

   localparam int MEM = 10;
   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  bdata;
   logic        bvalid;
   logic [31:0] instr;
   logic        wr;
   logic [3:0]  cnt;
   logic        busy;
   logic        done;
   logic [1:0]  err;

   always #5 clk = ~clk;

   instruction_loader #(
      .WORD_SIZE_IN_BYTES (4),
      .MEM_SIZE_IN_WORDS  (MEM),
      .TIMEOUT_CYCLES     (TMO),
      .HALT_WORD          (32'h0)
   ) dut (
      .i_clk               (clk),
      .i_reset             (rst_n),
      .i_start             (start),
      .i_byte              (bdata),
      .i_byte_valid        (bvalid),
      .o_instruction       (instr),
      .o_instruction_write (wr),
      .o_word_count        (cnt),
      .o_busy              (busy),
      .o_done              (done),
      .o_error             (err)
   );

   // Instruction memory model: sequential write port, pointer reset by the "debug unit".
   logic [31:0] mem [0:15];
   int          wptr    = 0;
   int          strobes = 0;
   logic        mem_clr = 1'b0;

   always @(posedge clk) begin
      if (mem_clr) wptr <= 0;
      else if (wr) begin
         mem[wptr[3:0]] <= instr;
         wptr <= wptr + 1;
      end
      if (wr) strobes <= strobes + 1;
   end

   typedef struct {
      logic [31:0] word;
      logic [3:0]  exp_count;
      logic        exp_done;
   } vec_t;

   vec_t        load_tbl [3];
   logic [31:0] saved [3];
   int          passed = 0;
   int          total  = 0;
   int          s0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_mem;
      mem_clr = 1'b1;
      tick();
      mem_clr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bdata  = b;
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
   endtask

   // max_gap 0: bytes on consecutive cycles; otherwise random idle gaps 1..max_gap.
   task automatic send_word(input logic [31:0] w, input int max_gap);
      logic [31:0] tmp;
      tmp = w;
      for (int b = 0; b < 4; b++) begin
         if (b > 0 && max_gap > 0) repeat ($urandom_range(1, max_gap)) tick();
         send_byte(tmp[31-8*b -: 8]);
      end
   endtask

   task automatic run_load(input int max_gap);
      clear_mem();
      pulse_start();
      check("load_busy", {31'b0, busy}, 32'd1);
      s0 = strobes;
      for (int i = 0; i < 3; i++) begin
         send_word(load_tbl[i].word, max_gap);
         check("load_strobe", {31'b0, wr}, 32'd1);
         check("load_instr", instr, load_tbl[i].word);
         check("load_count", {28'b0, cnt}, {28'b0, load_tbl[i].exp_count});
         check("load_done", {31'b0, done}, {31'b0, load_tbl[i].exp_done});
      end
      tick();
      tick();
      check("load_strobe_total", strobes - s0, 32'd3);
      check("load_err", {30'b0, err}, 32'd0);
      check("load_idle_after", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      load_tbl[0] = '{word: 32'h8C010004, exp_count: 4'd1, exp_done: 1'b0};
      load_tbl[1] = '{word: 32'h00221820, exp_count: 4'd2, exp_done: 1'b0};
      load_tbl[2] = '{word: 32'h00000000, exp_count: 4'd3, exp_done: 1'b1};

      rst_n  = 1'b0;
      start  = 1'b0;
      bdata  = 8'h00;
      bvalid = 1'b0;
      #1;
      check("rst_instr", instr, 32'd0);
      check("rst_strobe", {31'b0, wr}, 32'd0);
      check("rst_count", {28'b0, cnt}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_err", {30'b0, err}, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Bytes in IDLE are ignored.
      send_word(32'hDEADBEEF, 0);
      tick();
      check("idle_strobes", strobes, 32'd0);
      check("idle_count", {28'b0, cnt}, 32'd0);
      check("idle_busy", {31'b0, busy}, 32'd0);

      // Back-to-back load, then the same program with gaps gives identical memory.
      run_load(0);
      for (int i = 0; i < 3; i++) saved[i] = mem[i];
      for (int i = 0; i < 3; i++) check("mem_b2b", saved[i], load_tbl[i].word);
      run_load(12);
      for (int i = 0; i < 3; i++) check("mem_gap", mem[i], saved[i]);

      // Halt word in the last slot: normal finish.
      clear_mem();
      pulse_start();
      for (int i = 0; i < MEM - 1; i++) send_word(32'h11000000 + i, 0);
      send_word(32'h0, 0);
      check("lastslot_count", {28'b0, cnt}, 32'd10);
      check("lastslot_done", {31'b0, done}, 32'd1);
      check("lastslot_err", {30'b0, err}, 32'd0);
      tick();

      // Overflow: ten non-halt words, then further bytes ignored.
      clear_mem();
      pulse_start();
      check("ovf_restart_done", {31'b0, done}, 32'd0);
      for (int i = 0; i < MEM; i++) send_word(32'hA0000001 + (i << 8), 0);
      check("ovf_err", {30'b0, err}, 32'd1);
      check("ovf_done", {31'b0, done}, 32'd0);
      check("ovf_count", {28'b0, cnt}, 32'd10);
      tick();
      check("ovf_busy", {31'b0, busy}, 32'd0);
      check("ovf_mem_last", mem[9], 32'hA0000901);
      s0 = strobes;
      send_word(32'h12345678, 0);
      tick();
      tick();
      check("ovf_extra_strobes", strobes - s0, 32'd0);
      check("ovf_extra_count", {28'b0, cnt}, 32'd10);

      // Timeout: no timeout while empty; 16 idle cycles after a partial word.
      pulse_start();
      repeat (3 * TMO) tick();
      check("tmo_empty_busy", {31'b0, busy}, 32'd1);
      check("tmo_empty_err", {30'b0, err}, 32'd0);
      s0 = strobes;
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (TMO - 1) tick();
      check("tmo_early_err", {30'b0, err}, 32'd0);
      check("tmo_early_busy", {31'b0, busy}, 32'd1);
      tick();
      check("tmo_err", {30'b0, err}, 32'd2);
      check("tmo_busy", {31'b0, busy}, 32'd0);
      check("tmo_count", {28'b0, cnt}, 32'd0);
      tick();
      check("tmo_strobes", strobes - s0, 32'd0);

      // Reset during the third byte of word 2.
      clear_mem();
      pulse_start();
      send_word(32'hCAFEF00D, 0);
      send_byte(8'h01);
      send_byte(8'h02);
      s0 = strobes;
      bdata  = 8'h03;
      bvalid = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_instr", instr, 32'd0);
      check("mrst_count", {28'b0, cnt}, 32'd0);
      check("mrst_busy", {31'b0, busy}, 32'd0);
      check("mrst_strobe", {31'b0, wr}, 32'd0);
      bvalid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("mrst_strobes", strobes - s0, 32'd0);

      // Restart: one word plus halt, with a stray start mid-word.
      clear_mem();
      pulse_start();
      send_word(32'h20080005, 0);
      send_byte(8'h00);
      send_byte(8'h00);
      pulse_start();
      check("rxstart_count", {28'b0, cnt}, 32'd1);
      check("rxstart_busy", {31'b0, busy}, 32'd1);
      send_byte(8'h00);
      send_byte(8'h00);
      check("restart_count", {28'b0, cnt}, 32'd2);
      check("restart_done", {31'b0, done}, 32'd1);
      tick();
      check("restart_mem0", mem[0], 32'h20080005);
      check("restart_mem1", mem[1], 32'h00000000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Hard stop so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
      $fatal(1);
   end

endmodule
